// File: rtl/aap_fetch_unit.sv
// aap_fetch_unit: instruction fetch stage of the 16-bit AAP pipeline.
// Issues word reads at req_pc and buffers the results in a 2-entry prefetch FIFO.
// Hands the FIFO head to the decoder over a valid/ready handshake.
// A branch redirect flushes the FIFO and restarts fetching at redirect_pc.
//
// Ports
//   CLOCK_50     in   sole clock
//   reset        in   synchronous active-high reset
//   mem_rd       out  read request, held until mem_ack
//   mem_addr     out  word address of the read, stable while mem_rd=1
//   mem_rdata    in   read data, valid in the mem_ack cycle
//   mem_ack      in   one-cycle read completion
//   redirect     in   branch taken: flush and restart at redirect_pc
//   redirect_pc  in   restart address
//   fetchoutput  out  instruction word at the FIFO head
//   fetch_pc     out  address of fetchoutput
//   fetch_ext    out  fetchoutput is the second word of a 32-bit instruction
//   fetch_valid  out  head outputs valid
//   fetch_ready  in   decoder accepts the head when fetch_valid & fetch_ready
//
// Build option: define FETCH_CLKDIV_EN to gate new requests with a step
// divider that fires once every DIV_MAX+1 cycles.

module aap_fetch_unit #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       DIV_MAX  = 217
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [15:0]       fetchoutput,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic              fetch_ext,
  output logic              fetch_valid,
  input  logic              fetch_ready
);

  localparam int unsigned DATA_W = 16;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] pc;
    logic              ext;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_req_pc;
  logic              r_ext;
  logic              r_mem_rd;
  logic [ADDR_W-1:0] r_mem_addr;
  fetch_entry_t      r_head;
  fetch_entry_t      r_tail;
  logic [1:0]        r_cnt;
  logic              r_valid;

  logic              w_step;
  logic              w_mem_rd_nxt;
  logic              w_issue;
  logic [ADDR_W-1:0] w_issue_addr;
  logic              w_push;
  logic              w_pop;
  fetch_entry_t      w_new;

  // Request step enable
`ifdef FETCH_CLKDIV_EN
  localparam int unsigned DIV_W = 10;
  logic [DIV_W-1:0] r_div;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_div <= '0;
    end else if (r_div == DIV_W'(DIV_MAX)) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign w_step = (r_div == DIV_W'(DIV_MAX));
`else
  // DIV_MAX has no effect when the step divider is compiled out.
  assign w_step = 1'b1 | (DIV_MAX == 32'd0);
`endif

  // FSM state register
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state; a redirect flushes the FIFO, so IDLE may issue at once.
  // An ack coinciding with a redirect completes the read, so no DRAIN is needed.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_step && (redirect || (r_cnt < 2'd2))) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          w_state_nxt = S_IDLE;
        end else if (redirect) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem_ack) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs and FIFO control
  always_comb begin
    w_mem_rd_nxt = (w_state_nxt != S_IDLE);
    w_issue      = (r_state == S_IDLE) && (w_state_nxt == S_REQ);
    w_issue_addr = redirect ? redirect_pc : r_req_pc;
    w_push       = (r_state == S_REQ) && mem_ack && !redirect;
    w_pop        = r_valid && fetch_ready;
    w_new.data   = mem_rdata;
    w_new.pc     = r_req_pc;
    w_new.ext    = r_ext;
  end

  // Memory port; address is captured at issue so it survives a redirect in DRAIN
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_mem_rd   <= 1'b0;
      r_mem_addr <= RESET_PC;
    end else begin
      r_mem_rd <= w_mem_rd_nxt;
      if (w_issue) begin
        r_mem_addr <= w_issue_addr;
      end
    end
  end

  // Fetch PC and 32-bit continuation flag
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_req_pc <= RESET_PC;
      r_ext    <= 1'b0;
    end else if (redirect) begin
      r_req_pc <= redirect_pc;
      r_ext    <= 1'b0;
    end else if (w_push) begin
      r_req_pc <= r_req_pc + ADDR_W'(1);
      r_ext    <= mem_rdata[15] & ~r_ext;
    end
  end

  // Two-entry prefetch FIFO; r_head drives the outputs directly
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_cnt   <= 2'd0;
      r_valid <= 1'b0;
    end else if (redirect) begin
      r_cnt   <= 2'd0;
      r_valid <= 1'b0;
    end else begin
      case (r_cnt)
        2'd0: begin
          if (w_push) begin
            r_head  <= w_new;
            r_cnt   <= 2'd1;
            r_valid <= 1'b1;
          end
        end
        2'd1: begin
          if (w_push && w_pop) begin
            r_head <= w_new;
          end else if (w_push) begin
            r_tail <= w_new;
            r_cnt  <= 2'd2;
          end else if (w_pop) begin
            r_cnt   <= 2'd0;
            r_valid <= 1'b0;
          end
        end
        default: begin
          // Full: no read can be outstanding unless a pop makes room this cycle
          if (w_pop) begin
            r_head <= r_tail;
            if (w_push) begin
              r_tail <= w_new;
            end else begin
              r_cnt <= 2'd1;
            end
          end
        end
      endcase
    end
  end

  assign mem_rd      = r_mem_rd;
  assign mem_addr    = r_mem_addr;
  assign fetchoutput = r_head.data;
  assign fetch_pc    = r_head.pc;
  assign fetch_ext   = r_head.ext;
  assign fetch_valid = r_valid;

endmodule
